serial_digit_adder: RTL

- Multi-cycle add/subtract unit that processes WIDTH-bit operands DIGIT bits per clock, least-significant digit first, through one DIGIT-bit ripple stage built from full-adder cells.
- Sits between a requester using a start/done handshake and the ALU datapath.
- Trades latency for area against a full-width ripple adder.
- Produces sum, carry, signed-overflow and zero flags.

---
 rtl/serial_digit_adder_pkg.sv | 15 +
 rtl/serial_digit_adder_if.sv | 26 ++
 rtl/serial_digit_adder_ripple.sv | 42 ++++
 rtl/serial_digit_adder.sv | 131 +++++++++++++
 4 files changed

// File: rtl/serial_digit_adder_pkg.sv
// Shared types and helpers for the digit-serial add/subtract unit.
package serial_digit_adder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Digit counter width; a single-digit configuration still needs one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/serial_digit_adder_if.sv
// Requester-side handshake and result bus of the digit-serial adder.
interface serial_digit_adder_if #(
    parameter int WIDTH = 8
) ();
    logic             start;
    logic             subtract;
    logic             carryin;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] sum;
    logic             carryout;
    logic             overflow;
    logic             zero;

    modport master (
        output start, subtract, carryin, a, b,
        input  busy, done, sum, carryout, overflow, zero
    );

    modport slave (
        input  start, subtract, carryin, a, b,
        output busy, done, sum, carryout, overflow, zero
    );
endinterface

// File: rtl/serial_digit_adder_ripple.sv
// One DIGIT-bit ripple stage built from a chain of full-adder cells.
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);
    logic p;

    assign p    = a ^ b;
    assign s    = p ^ cin;
    assign cout = (a & b) | (p & cin);
endmodule

module ripple_digit_adder #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             carryin,
    output logic [DIGIT-1:0] sum,
    output logic             carryout,
    output logic             msbcarryin
);
    logic [DIGIT:0] c;

    assign c[0] = carryin;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder_cell u_fa (
            .a    (a[i]),
            .b    (b[i]),
            .cin  (c[i]),
            .s    (sum[i]),
            .cout (c[i+1])
        );
    end

    assign carryout   = c[DIGIT];
    assign msbcarryin = c[DIGIT-1];
endmodule

// File: rtl/serial_digit_adder.sv
// Digit-serial add/subtract: WIDTH-bit operands, DIGIT bits per clock, LSD first.
module serial_digit_adder
    import serial_digit_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 4
) (
    input  logic                clk,
    input  logic                reset,
    serial_digit_adder_if.slave bus
);
    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = cnt_width(N);

    state_t state_q, state_d;

    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic             carry_q, carry_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;
    logic             zero_q, zero_d;

    logic             accept;
    logic             last_digit;
    logic [DIGIT-1:0] dig_sum;
    logic             dig_cout;
    logic             dig_msbcin;
    logic [WIDTH-1:0] res_next;

    ripple_digit_adder #(.DIGIT(DIGIT)) u_digit (
        .a          (a_q[DIGIT-1:0]),
        .b          (b_q[DIGIT-1:0]),
        .carryin    (carry_q),
        .sum        (dig_sum),
        .carryout   (dig_cout),
        .msbcarryin (dig_msbcin)
    );

    // A new request is taken in IDLE and in the DONE cycle, never while running.
    assign accept     = bus.start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign last_digit = (cnt_q == CNT_W'(N - 1));
    // The fresh digit enters at the top; after N shifts the word is LSD-aligned.
    assign res_next   = (res_q >> DIGIT) | (WIDTH'(dig_sum) << (WIDTH - DIGIT));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last_digit) state_d = ST_DONE;
            ST_DONE: state_d = accept ? ST_RUN : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bus.busy     = (state_q == ST_RUN);
        bus.done     = (state_q == ST_DONE);
        bus.sum      = sum_q;
        bus.carryout = cout_q;
        bus.overflow = ovf_q;
        bus.zero     = zero_q;
    end

    always_comb begin
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;
        if (accept) begin
            // Subtraction runs as a + ~b + ~borrow through the same adder.
            a_d     = bus.a;
            b_d     = bus.subtract ? ~bus.b : bus.b;
            carry_d = bus.carryin ^ bus.subtract;
            cnt_d   = '0;
        end else if (state_q == ST_RUN) begin
            a_d     = a_q >> DIGIT;
            b_d     = b_q >> DIGIT;
            res_d   = res_next;
            carry_d = dig_cout;
            cnt_d   = cnt_q + CNT_W'(1);
            if (last_digit) begin
                sum_d  = res_next;
                cout_d = dig_cout;
                ovf_d  = dig_msbcin ^ dig_cout;
                zero_d = (res_next == '0);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

endmodule
